// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   XLEN             - datapath / address width
//   fetch_state_t    - fetch FSM encoding (REQ, DRAIN, HOLD)
//   NOP_INSTR        - bubble encoding (sll $0,$0,0)
//   DEFAULT_RESET_PC - PC loaded on reset unless overridden
//   align_word()     - clears the byte-offset bits of an address
package if_fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Force a target onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge channel.
//   imem_req   - fetch request, held until acknowledged
//   imem_addr  - word-aligned request address, stable while imem_req=1
//   imem_ack   - one-cycle response strobe
//   imem_rdata - instruction word, valid while imem_ack=1
// master: fetch stage; slave: instruction memory.
interface if_fetch_if
  import if_fetch_pkg::*;
();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_pc_next_sel.sv
// Combinational next-PC selection for the fetch stage.
//   i_pc          - current fetch PC
//   i_advance     - current fetch accepted, step to PC+4
//   i_PCSrcD      - taken branch (highest priority), target i_PCBranchD
//   i_JumpD       - jump, target i_PCJumpD
//   o_pc_next_c   - PC for the next cycle (targets word-aligned)
//   o_pc_plus4_c  - PC+4, modulo 2^32
//   o_redirect_c  - a branch or jump overrides sequential fetch
module pc_next_sel
  import if_fetch_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_advance,
  input  logic            i_PCSrcD,
  input  logic [XLEN-1:0] i_PCBranchD,
  input  logic            i_JumpD,
  input  logic [XLEN-1:0] i_PCJumpD,
  output logic [XLEN-1:0] o_pc_next_c,
  output logic [XLEN-1:0] o_pc_plus4_c,
  output logic            o_redirect_c
);

  // Natural wrap: 32'hFFFF_FFFC + 4 = 0.
  assign o_pc_plus4_c = i_pc + XLEN'(4);
  assign o_redirect_c = i_PCSrcD | i_JumpD;

  // Branch beats jump; either beats sequential advance.
  always_comb begin
    o_pc_next_c = i_pc;
    if (i_PCSrcD) begin
      o_pc_next_c = align_word(i_PCBranchD);
    end else if (i_JumpD) begin
      o_pc_next_c = align_word(i_PCJumpD);
    end else if (i_advance) begin
      o_pc_next_c = o_pc_plus4_c;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: producer side of the IF/ID pipeline register.
// Owns the PC, fetches from a variable-latency memory over imem (req/ack),
// and presents either a fetched instruction or a NOP bubble to IF/ID.
//   clk, rst       - clock, synchronous active-high reset
//   imem           - if_fetch_if.master, instruction-memory channel
//   i_StallF       - hold fetch outputs and PC
//   i_PCSrcD/i_PCBranchD - taken branch from ID and its target
//   i_JumpD/i_PCJumpD    - jump from ID and its target
//   o_instr, o_PCPlus4F  - instruction and its PC+4 to IF/ID
//   o_InstrValidF  - 1 = o_instr is real, 0 = bubble
//   o_bubble_cnt   - bubble counter, present only when IF_BUBBLE_CNT_EN
//                    is defined, otherwise tied to 0
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = if_fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_if.master      imem,
  input  logic            i_StallF,
  input  logic            i_PCSrcD,
  input  logic [XLEN-1:0] i_PCBranchD,
  input  logic            i_JumpD,
  input  logic [XLEN-1:0] i_PCJumpD,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_PCPlus4F,
  output logic            o_InstrValidF,
  output logic [XLEN-1:0] o_bubble_cnt
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;         // architectural fetch PC
  logic [XLEN-1:0] r_addr;       // address on the bus; lags r_pc in DRAIN
  logic [XLEN-1:0] r_buf_instr;  // word captured while stalled
  logic [XLEN-1:0] r_buf_pc4;

  logic            w_req;
  logic            w_ack;
  logic            w_advance;
  logic            w_redirect;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_plus4;

  // Request is a decode of the state register, squashed while in reset.
  assign w_req          = (r_state != ST_HOLD) && !rst;
  assign w_ack          = imem.imem_ack && w_req;
  assign w_advance      = (r_state == ST_REQ) && w_ack;
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_addr;

  pc_next_sel u_pc_next_sel (
    .i_pc         (r_pc),
    .i_advance    (w_advance),
    .i_PCSrcD     (i_PCSrcD),
    .i_PCBranchD  (i_PCBranchD),
    .i_JumpD      (i_JumpD),
    .i_PCJumpD    (i_PCJumpD),
    .o_pc_next_c  (w_pc_next),
    .o_pc_plus4_c (w_pc_plus4),
    .o_redirect_c (w_redirect)
  );

  // Fetch FSM, stall buffer and IF/ID outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_REQ;
      r_pc          <= RESET_PC;
      r_addr        <= RESET_PC;
      r_buf_instr   <= NOP_INSTR;
      r_buf_pc4     <= '0;
      o_instr       <= NOP_INSTR;
      o_PCPlus4F    <= '0;
      o_InstrValidF <= 1'b0;
    end else begin
      r_pc   <= w_pc_next;
      r_addr <= w_pc_next;
      if (w_redirect) begin
        r_buf_instr   <= NOP_INSTR;
        r_buf_pc4     <= '0;
        o_instr       <= NOP_INSTR;
        o_PCPlus4F    <= '0;
        o_InstrValidF <= 1'b0;
        // An unacknowledged request cannot be withdrawn: keep its address
        // on the bus and discard the response when it arrives.
        if (r_state != ST_HOLD && !w_ack) begin
          r_state <= ST_DRAIN;
          r_addr  <= r_addr;
        end else begin
          r_state <= ST_REQ;
        end
      end else begin
        case (r_state)
          ST_REQ: begin
            if (w_ack) begin
              if (!i_StallF) begin
                o_instr       <= imem.imem_rdata;
                o_PCPlus4F    <= w_pc_plus4;
                o_InstrValidF <= 1'b1;
              end else begin
                r_buf_instr <= imem.imem_rdata;
                r_buf_pc4   <= w_pc_plus4;
                r_state     <= ST_HOLD;
              end
            end else if (!i_StallF) begin
              o_instr       <= NOP_INSTR;
              o_PCPlus4F    <= '0;
              o_InstrValidF <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (!i_StallF) begin
              o_instr       <= r_buf_instr;
              o_PCPlus4F    <= r_buf_pc4;
              o_InstrValidF <= 1'b1;
              r_buf_instr   <= NOP_INSTR;
              r_buf_pc4     <= '0;
              r_state       <= ST_REQ;
            end
          end
          ST_DRAIN: begin
            if (!i_StallF) begin
              o_instr       <= NOP_INSTR;
              o_PCPlus4F    <= '0;
              o_InstrValidF <= 1'b0;
            end
            if (w_ack) begin
              r_state <= ST_REQ;
            end else begin
              r_addr <= r_addr;
            end
          end
          default: begin
            r_state <= ST_REQ;
          end
        endcase
      end
    end
  end

`ifdef IF_BUBBLE_CNT_EN
  logic w_bubble;

  // A bubble reaches IF/ID on an unstalled cycle with no word to deliver.
  assign w_bubble = !i_StallF &&
                    (w_redirect || r_state == ST_DRAIN ||
                     (r_state == ST_REQ && !w_ack));

  // Saturating bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_bubble_cnt <= '0;
    end else if (w_bubble && (o_bubble_cnt != '1)) begin
      o_bubble_cnt <= o_bubble_cnt + XLEN'(1);
    end
  end
`else
  assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: table-driven zero-wait sequence plus
// hand-written multi-cycle sequences (wait states, drain, reset mid-flight).
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, pcsrc, jump;
  logic [31:0] br, jt;
  logic [31:0] instr, pc4, bcnt;
  logic        valid;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned lat      = 0;
  int unsigned wait_cnt = 0;

  if_fetch_if u_if ();

  if_fetch #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (u_if),
    .i_StallF     (stall),
    .i_PCSrcD     (pcsrc),
    .i_PCBranchD  (br),
    .i_JumpD      (jump),
    .i_PCJumpD    (jt),
    .o_instr      (instr),
    .o_PCPlus4F   (pc4),
    .o_InstrValidF(valid),
    .o_bubble_cnt (bcnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: ack after `lat` extra cycles of held request.
  always_ff @(posedge clk) begin
    if (rst || !u_if.imem_req || u_if.imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign u_if.imem_ack   = u_if.imem_req && (wait_cnt >= lat);
  assign u_if.imem_rdata = u_if.imem_ack ? word_at(u_if.imem_addr) : 32'hDEAD_BEEF;

  function automatic logic [31:0] exp_cnt(input int unsigned n);
`ifdef IF_BUBBLE_CNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reset for one edge; rst stays high until the next step drops it.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; jump = 1'b0; br = '0; jt = '0;
    #1;
    check({tag, ".req"}, 32'(u_if.imem_req), 32'h0);
    @(posedge clk); #1;
    check({tag, ".instr"}, instr, 32'h0);
    check({tag, ".pc4"},   pc4,   32'h0);
    check({tag, ".valid"}, 32'(valid), 32'h0);
    check({tag, ".bcnt"},  bcnt,  32'h0);
  endtask

  task automatic step(input logic s, input logic p, input logic [31:0] b,
                      input logic j, input logic [31:0] t,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic [31:0] e_instr, input logic [31:0] e_pc4,
                      input logic e_val, input int unsigned e_cnt, input string tag);
    @(negedge clk);
    rst = 1'b0; stall = s; pcsrc = p; br = b; jump = j; jt = t;
    #1;
    check({tag, ".req"}, 32'(u_if.imem_req), 32'(e_req));
    if (e_req) check({tag, ".addr"}, u_if.imem_addr, e_addr);
    @(posedge clk); #1;
    check({tag, ".instr"}, instr, e_instr);
    check({tag, ".pc4"},   pc4,   e_pc4);
    check({tag, ".valid"}, 32'(valid), 32'(e_val));
    check({tag, ".bcnt"},  bcnt,  exp_cnt(e_cnt));
  endtask

  typedef struct {
    logic        s, p;
    logic [31:0] b;
    logic        j;
    logic [31:0] t;
    logic        e_req;
    logic [31:0] e_addr, e_instr, e_pc4;
    logic        e_val;
    int unsigned e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic p, input logic [31:0] b,
                              input logic j, input logic [31:0] t, input logic e_req,
                              input logic [31:0] e_addr, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic e_val,
                              input int unsigned e_cnt);
    vec_t v;
    v.s = s; v.p = p; v.b = b; v.j = j; v.t = t; v.e_req = e_req;
    v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc4 = e_pc4;
    v.e_val = e_val; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    // Zero-wait memory: stream, stall with capture, redirects, PC wrap.
    tbl[0]  = mk(0,0,0,0,0,            1,32'h0,        word_at(32'h0),   32'h4,  1,0);
    tbl[1]  = mk(0,0,0,0,0,            1,32'h4,        word_at(32'h4),   32'h8,  1,0);
    tbl[2]  = mk(0,0,0,0,0,            1,32'h8,        word_at(32'h8),   32'hC,  1,0);
    tbl[3]  = mk(1,0,0,0,0,            1,32'hC,        word_at(32'h8),   32'hC,  1,0);
    tbl[4]  = mk(1,0,0,0,0,            0,32'h0,        word_at(32'h8),   32'hC,  1,0);
    tbl[5]  = mk(1,0,0,0,0,            0,32'h0,        word_at(32'h8),   32'hC,  1,0);
    tbl[6]  = mk(1,0,0,0,0,            0,32'h0,        word_at(32'h8),   32'hC,  1,0);
    tbl[7]  = mk(0,0,0,0,0,            0,32'h0,        word_at(32'hC),   32'h10, 1,0);
    tbl[8]  = mk(0,0,0,0,0,            1,32'h10,       word_at(32'h10),  32'h14, 1,0);
    tbl[9]  = mk(0,1,32'h200,1,32'h300,1,32'h14,       32'h0,            32'h0,  0,1);
    tbl[10] = mk(0,0,0,0,0,            1,32'h200,      word_at(32'h200), 32'h204,1,1);
    tbl[11] = mk(0,0,0,1,32'h303,      1,32'h204,      32'h0,            32'h0,  0,2);
    tbl[12] = mk(0,0,0,0,0,            1,32'h300,      word_at(32'h300), 32'h304,1,2);
    tbl[13] = mk(1,1,32'h203,0,0,      1,32'h304,      32'h0,            32'h0,  0,2);
    tbl[14] = mk(0,0,0,0,0,            1,32'h200,      word_at(32'h200), 32'h204,1,2);
    tbl[15] = mk(0,0,0,1,32'hFFFF_FFFC,1,32'h204,      32'h0,            32'h0,  0,3);
    tbl[16] = mk(0,0,0,0,0,            1,32'hFFFF_FFFC,word_at(32'hFFFF_FFFC),32'h0,1,3);
    tbl[17] = mk(0,0,0,0,0,            1,32'h0,        word_at(32'h0),   32'h4,  1,3);

    lat = 0;
    do_reset("rst0");
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].s, tbl[i].p, tbl[i].b, tbl[i].j, tbl[i].t, tbl[i].e_req,
           tbl[i].e_addr, tbl[i].e_instr, tbl[i].e_pc4, tbl[i].e_val,
           tbl[i].e_cnt, $sformatf("tbl%0d", i));
    end

    // Two wait states: two bubbles before each word.
    lat = 2;
    do_reset("rst_lat");
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      logic        v;
      a = 32'(4 * (k / 3));
      v = (k % 3) == 2;
      step(0,0,0,0,0, 1, a, v ? word_at(a) : 32'h0, v ? a + 32'h4 : 32'h0, v,
           (k + 1) - (k + 1) / 3, $sformatf("lat%0d", k));
    end

    // Branch while 0x8 is outstanding: address held, data dropped.
    step(0,1,32'h100,0,0, 1,32'h8,   32'h0,0,0, 5, "drain0");
    step(0,0,0,0,0,       1,32'h8,   32'h0,0,0, 6, "drain1");
    step(0,0,0,0,0,       1,32'h8,   32'h0,0,0, 7, "drain2");
    step(0,0,0,0,0,       1,32'h100, 32'h0,0,0, 8, "drain3");
    step(0,0,0,0,0,       1,32'h100, 32'h0,0,0, 9, "drain4");
    step(0,0,0,0,0,       1,32'h100, word_at(32'h100),32'h104,1, 9, "drain5");

    // Second redirect during DRAIN moves PC only.
    step(0,1,32'h400,0,0, 1,32'h104, 32'h0,0,0, 10, "redr0");
    step(0,0,0,1,32'h500, 1,32'h104, 32'h0,0,0, 11, "redr1");
    step(0,0,0,0,0,       1,32'h104, 32'h0,0,0, 12, "redr2");
    step(0,1,32'h600,0,0, 1,32'h500, 32'h0,0,0, 13, "redr3");

    // Reset while in DRAIN: restart at RESET_PC.
    do_reset("rst_drain");
    step(0,0,0,0,0, 1,32'h0, 32'h0,0,0, 1, "rd0");
    step(0,0,0,0,0, 1,32'h0, 32'h0,0,0, 2, "rd1");
    step(0,0,0,0,0, 1,32'h0, word_at(32'h0),32'h4,1, 2, "rd2");

    // Reset while in HOLD.
    lat = 0;
    do_reset("rst1");
    step(0,0,0,0,0, 1,32'h0, word_at(32'h0),32'h4,1, 0, "rh0");
    step(1,0,0,0,0, 1,32'h4, word_at(32'h0),32'h4,1, 0, "rh1");
    step(1,0,0,0,0, 0,32'h0, word_at(32'h0),32'h4,1, 0, "rh2");
    do_reset("rst_hold");
    step(0,0,0,0,0, 1,32'h0, word_at(32'h0),32'h4,1, 0, "rh3");
    step(0,0,0,0,0, 1,32'h4, word_at(32'h4),32'h8,1, 0, "rh4");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
